// File: rtl/gpio_in_pkg.sv
// Shared types and width helpers for the GPIO input conditioner.
package gpio_in_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int IDX_W_MAX      = 16;

  // Counter/index width for a range of n values; never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic                 level;
  } evt_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input line: 2-flop synchroniser, sample-counting debouncer, clean level
// and registered rise/fall pulses. chg flags the edge on which stable flips.
module gpio_debounce_bit
  import gpio_in_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic sample_en,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic chg
);

  localparam int CNT_W = bits_for(DEB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == CNT_W'(DEB_CYCLES - 1));
  assign chg    = (sync2 != stable) && sample_en && at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= chg & sync2;
      fall  <= chg & ~sync2;
      // Any return to the accepted level restarts qualification, tick or not.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (sample_en) begin
        if (at_end) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Debounces the virtual-board input vector and serialises every accepted level
// change into a valid/ready event stream, lowest bit index first.
module gpio_in_conditioner
  import gpio_in_pkg::*;
#(
  parameter  int WIDTH      = 43,
  parameter  int DEB_CYCLES = DEB_CYCLES_DEF,
  localparam int IDX_W      = bits_for(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_level,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0]     chg;
  logic [WIDTH-1:0]     pending;
  logic [WIDTH-1:0]     clr_mask;
  logic                 xfer;
  logic                 ovf_set;
  logic [IDX_W_MAX-1:0] found_idx;
  logic                 found_level;
  evt_t                 evt_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw_in[g]),
      .sample_en(sample_en),
      .stable   (stable_out[g]),
      .rise     (rise_pulse[g]),
      .fall     (fall_pulse[g]),
      .chg      (chg[g])
    );
  end

  // Lowest set pending bit wins; scanning downwards lets the last hit stick.
  always_comb begin
    found_idx   = '0;
    found_level = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found_idx   = IDX_W_MAX'(i);
        found_level = stable_out[i];
      end
    end
  end

  assign xfer      = evt_valid & evt_ready;
  assign clr_mask  = xfer ? (WIDTH'(1) << evt_q.idx) : '0;
  // A new edge on a bit whose event is still queued (and not leaving now) merges.
  assign ovf_set   = |(chg & pending & ~clr_mask);
  assign evt_idx   = evt_q.idx[IDX_W-1:0];
  assign evt_level = evt_q.level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      evt_valid <= 1'b0;
      evt_q     <= '0;
      evt_ovf   <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | chg;

      if (ovf_set) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end

      // Transfer always leaves one idle cycle before the next load.
      if (xfer) begin
        evt_valid <= 1'b0;
      end else if (!evt_valid && (|pending)) begin
        evt_valid   <= 1'b1;
        evt_q.idx   <= found_idx;
        evt_q.level <= found_level;
      end
    end
  end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with WIDTH=8, DEB_CYCLES=4.
module tb_gpio_in_conditioner;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] raw_in;
  logic             sample_en;
  logic [WIDTH-1:0] stable_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_level;
  logic             evt_ovf;
  logic             ovf_clr;

  int n_checks;
  int n_errors;

  gpio_in_conditioner #(
    .WIDTH     (WIDTH),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .sample_en (sample_en),
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_level (evt_level),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs and samples both land 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic seen;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    raw_in    = '0;
    sample_en = 1'b1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset state
    ticks(2);
    check("rst_stable", stable_out, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_ovf", evt_ovf, 0);
    rst_n = 1'b1;

    // Basic rise on bit 0: accept at edge 5, event at edge 6, taken at edge 7
    raw_in = 8'h01;
    ticks(5);
    check("basic_pre_stable", stable_out, 8'h00);
    tick();
    check("basic_stable", stable_out, 8'h01);
    check("basic_rise", rise_pulse, 8'h01);
    check("basic_fall", fall_pulse, 8'h00);
    check("basic_valid_early", evt_valid, 0);
    tick();
    check("basic_rise_one_cycle", rise_pulse, 8'h00);
    check("basic_valid", evt_valid, 1);
    check("basic_idx", evt_idx, 0);
    check("basic_level", evt_level, 1);
    tick();
    check("basic_taken", evt_valid, 0);

    // Glitch on bit 5 shorter than the debounce window
    seen   = 1'b0;
    raw_in = 8'h21;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) raw_in = 8'h01;
      tick();
      seen = seen | stable_out[5] | rise_pulse[5] | fall_pulse[5] | evt_valid;
    end
    check("glitch_quiet", seen, 0);
    check("glitch_stable", stable_out, 8'h01);

    // Bit 0 back low, drain its event
    raw_in = 8'h00;
    ticks(12);
    check("fall_stable", stable_out, 8'h00);
    check("fall_drained", evt_valid, 0);

    // Bits 0 and 2 rise together: idx 0, bubble, idx 2
    raw_in = 8'h05;
    ticks(6);
    check("sim_stable", stable_out, 8'h05);
    check("sim_rise", rise_pulse, 8'h05);
    tick();
    check("sim_v0", evt_valid, 1);
    check("sim_idx0", evt_idx, 0);
    check("sim_lvl0", evt_level, 1);
    tick();
    check("sim_bubble", evt_valid, 0);
    tick();
    check("sim_v1", evt_valid, 1);
    check("sim_idx1", evt_idx, 2);
    check("sim_lvl1", evt_level, 1);
    tick();
    check("sim_done", evt_valid, 0);

    // Sparse sample ticks on edges 3,7,11,15: bit 3 accepted at edge 15
    raw_in = 8'h0D;
    for (int m = 0; m < 19; m++) begin
      sample_en = ((m % 4) == 3);
      tick();
      if (m == 14) check("sparse_edge14", stable_out[3], 0);
      if (m == 15) check("sparse_edge15", stable_out[3], 1);
    end
    // No sample ticks at all: bit 3 never drops
    sample_en = 1'b0;
    raw_in    = 8'h05;
    ticks(20);
    check("nosample_hold", stable_out, 8'h0D);
    sample_en = 1'b1;
    ticks(10);
    check("resample_stable", stable_out, 8'h05);
    check("resample_drained", evt_valid, 0);

    // Backpressure: bit 0 rises then falls while the consumer stalls
    raw_in = 8'h04;
    ticks(10);
    check("bp_setup", stable_out, 8'h04);
    evt_ready = 1'b0;
    raw_in    = 8'h05;
    ticks(8);
    check("bp_valid", evt_valid, 1);
    check("bp_idx", evt_idx, 0);
    check("bp_lvl", evt_level, 1);
    check("bp_no_ovf", evt_ovf, 0);
    raw_in = 8'h04;
    ticks(8);
    check("bp_stable", stable_out, 8'h04);
    check("bp_ovf", evt_ovf, 1);
    check("bp_held_valid", evt_valid, 1);
    check("bp_held_idx", evt_idx, 0);
    check("bp_held_lvl", evt_level, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", evt_ovf, 0);

    // Reset in the middle of counting bit 1 (cnt=2 after edge 3)
    raw_in = 8'h06;
    ticks(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_stable", stable_out, 8'h00);
    check("midrst_valid", evt_valid, 0);
    check("midrst_rise", rise_pulse, 8'h00);
    ticks(2);
    evt_ready = 1'b1;
    rst_n     = 1'b1;
    ticks(5);
    check("postrst_pre", stable_out, 8'h00);
    tick();
    check("postrst_stable", stable_out, 8'h06);
    check("postrst_rise", rise_pulse, 8'h06);
    tick();
    check("postrst_v0", evt_valid, 1);
    check("postrst_idx0", evt_idx, 1);
    tick();
    check("postrst_bubble", evt_valid, 0);
    tick();
    check("postrst_idx1", evt_idx, 2);
    check("postrst_lvl1", evt_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
